// File: rtl/frog_game_if.sv
// Signal bundle between the frog game controller and its key/detector inputs
// and display/LED outputs.
interface frog_game_if #(
  parameter int LIVES_W = 2,
  parameter int SCORE_W = 4
);
  logic [3:0]         keys;
  logic               hit;
  logic               goal;
  logic               lightOn;
  logic               playing;
  logic               gameOver;
  logic [LIVES_W-1:0] lives;
  logic [SCORE_W-1:0] score;
  logic               respawn;

  modport master (
    output keys, hit, goal,
    input  lightOn, playing, gameOver, lives, score, respawn
  );

  modport slave (
    input  keys, hit, goal,
    output lightOn, playing, gameOver, lives, score, respawn
  );
endinterface

// File: rtl/frog_game_ctrl.sv
// Game-lifecycle sequencer for the frog game: READY / PLAY / DYING / OVER,
// with lives, saturating score, respawn delay and edge-qualified keys.
module frog_game_ctrl #(
  parameter int LIVES   = 3,
  parameter int RESPAWN = 16,
  parameter int SCORE_W = 4
) (
  input  logic        Clock,
  input  logic        reset,
  frog_game_if.slave  bus
);
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int CNT_W   = (RESPAWN > 1) ? $clog2(RESPAWN) : 1;

  typedef enum logic [1:0] {READY, PLAY, DYING, OVER} state_t;

  state_t           state;
  logic [3:0]       keys_q;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       press;
  logic             start_press;

  assign press       = bus.keys & ~keys_q;
  assign start_press = press[1] & ~bus.keys[3] & ~bus.keys[2] & ~bus.keys[0];

  // NOTE: state and outputs are sequential, so every assignment here is
  // non-blocking; blocking ones would let later statements see new values.
  always_ff @(posedge Clock) begin
    if (reset) begin
      state        <= READY;
      // All-ones so a key held through reset needs a release before it counts.
      keys_q       <= 4'b1111;
      cnt          <= '0;
      bus.lightOn  <= 1'b1;
      bus.playing  <= 1'b0;
      bus.gameOver <= 1'b0;
      bus.lives    <= LIVES_W'(LIVES);
      bus.score    <= '0;
      bus.respawn  <= 1'b0;
    end else begin
      keys_q      <= bus.keys;
      bus.respawn <= 1'b0;
      case (state)
        READY: begin
          if (start_press) begin
            state       <= PLAY;
            bus.lightOn <= 1'b0;
            bus.playing <= 1'b1;
            bus.lives   <= LIVES_W'(LIVES);
            bus.score   <= '0;
            bus.respawn <= 1'b1;
          end
        end
        PLAY: begin
          if (bus.hit) begin
            bus.playing <= 1'b0;
            if (bus.lives == LIVES_W'(1)) begin
              state        <= OVER;
              bus.gameOver <= 1'b1;
              bus.lives    <= '0;
            end else begin
              state     <= DYING;
              bus.lives <= bus.lives - LIVES_W'(1);
              cnt       <= CNT_W'(RESPAWN - 1);
            end
          end else if (bus.goal) begin
            if (bus.score != '1) bus.score <= bus.score + SCORE_W'(1);
            bus.respawn <= 1'b1;
          end
        end
        DYING: begin
          if (cnt == '0) begin
            state       <= PLAY;
            bus.playing <= 1'b1;
            bus.respawn <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        OVER: begin
          if (start_press) begin
            state        <= READY;
            bus.lightOn  <= 1'b1;
            bus.gameOver <= 1'b0;
          end
        end
        default: begin
          state        <= READY;
          bus.lightOn  <= 1'b1;
          bus.playing  <= 1'b0;
          bus.gameOver <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_frog_game_ctrl.sv
// Directed bench for frog_game_ctrl: a vector table for start/score behaviour
// plus hand sequences for the dying delay, game over and reset mid-DYING.
module tb_frog_game_ctrl;
  localparam int LIVES   = 3;
  localparam int RESPAWN = 16;
  localparam int SCORE_W = 2;

  logic Clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  frog_game_if #(.LIVES_W(2), .SCORE_W(SCORE_W)) bus ();

  frog_game_ctrl #(.LIVES(LIVES), .RESPAWN(RESPAWN), .SCORE_W(SCORE_W)) dut (
    .Clock (Clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic       rst;
    logic [3:0] keys;
    logic       hit;
    logic       goal;
    logic       l;
    logic       p;
    logic       o;
    logic [1:0] lives;
    logic [1:0] score;
    logic       r;
  } vec_t;

  vec_t tbl[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic l, input logic p, input logic o,
                            input logic [1:0] lv, input logic [1:0] sc, input logic r);
    check({tag, ".lightOn"},  32'(bus.lightOn),  32'(l));
    check({tag, ".playing"},  32'(bus.playing),  32'(p));
    check({tag, ".gameOver"}, 32'(bus.gameOver), 32'(o));
    check({tag, ".lives"},    32'(bus.lives),    32'(lv));
    check({tag, ".score"},    32'(bus.score),    32'(sc));
    check({tag, ".respawn"},  32'(bus.respawn),  32'(r));
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    //            rst   keys     hit   goal  l     p     o     lives  score  r
    tbl[0]  = '{1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0};
    tbl[4]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0};
    tbl[5]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0};
    tbl[6]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0};
    tbl[8]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 1'b1};
    tbl[9]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 2'd1, 1'b1};
    tbl[11] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd1, 1'b0};
    tbl[12] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 2'd2, 1'b1};
    tbl[13] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd2, 1'b0};
    tbl[14] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 2'd3, 1'b1};
    tbl[15] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd3, 1'b0};
    tbl[16] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 2'd3, 1'b1};
    tbl[17] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd3, 1'b0};
    tbl[18] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 2'd3, 1'b1};
    tbl[19] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd3, 1'b0};
    tbl[20] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd3, 1'b0};

    reset    = 1'b1;
    bus.keys = 4'b0010;
    bus.hit  = 1'b0;
    bus.goal = 1'b0;

    // U held through reset, start, saturating score, hit beating goal.
    for (int i = 0; i < 21; i++) begin
      reset    = tbl[i].rst;
      bus.keys = tbl[i].keys;
      bus.hit  = tbl[i].hit;
      bus.goal = tbl[i].goal;
      step();
      expect_all($sformatf("vec%0d", i), tbl[i].l, tbl[i].p, tbl[i].o,
                 tbl[i].lives, tbl[i].score, tbl[i].r);
    end

    // DYING lasts RESPAWN cycles and ignores hit/goal pulses.
    for (int k = 1; k < RESPAWN; k++) begin
      bus.hit  = k[0];
      bus.goal = ~k[0];
      step();
      expect_all($sformatf("dying1_%0d", k), 1'b0, 1'b0, 1'b0, 2'd2, 2'd3, 1'b0);
    end
    bus.hit  = 1'b1;
    bus.goal = 1'b0;
    step();
    expect_all("respawn1", 1'b0, 1'b1, 1'b0, 2'd2, 2'd3, 1'b1);

    // Hit held continuously: exactly one life per entry into PLAY.
    step();
    expect_all("hold_hit1", 1'b0, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0);
    for (int k = 1; k < RESPAWN; k++) begin
      step();
      expect_all($sformatf("dying2_%0d", k), 1'b0, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0);
    end
    step();
    expect_all("respawn2", 1'b0, 1'b1, 1'b0, 2'd1, 2'd3, 1'b1);
    step();
    expect_all("over", 1'b0, 1'b0, 1'b1, 2'd0, 2'd3, 1'b0);
    bus.hit = 1'b0;
    step();
    expect_all("over_hold", 1'b0, 1'b0, 1'b1, 2'd0, 2'd3, 1'b0);

    // OVER -> READY keeps score/lives; blocked start combinations.
    bus.keys = 4'b0010; step();
    expect_all("to_ready", 1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0);
    bus.keys = 4'b0000; step();
    bus.keys = 4'b1010; step();
    expect_all("l_and_u", 1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0);
    bus.keys = 4'b0000; step();
    bus.keys = 4'b0001; step();
    bus.keys = 4'b0011; step();
    expect_all("u_with_d", 1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0);
    bus.keys = 4'b0000; step();
    bus.keys = 4'b0010; step();
    expect_all("restart", 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 1'b1);

    // Reset during DYING abandons the respawn countdown.
    bus.keys = 4'b0000;
    bus.goal = 1'b1; step();
    expect_all("goal2", 1'b0, 1'b1, 1'b0, 2'd3, 2'd1, 1'b1);
    bus.goal = 1'b0;
    bus.hit  = 1'b1; step();
    expect_all("hit3", 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0);
    bus.hit = 1'b0;
    for (int k = 0; k < 4; k++) step();
    reset = 1'b1; step();
    expect_all("mid_reset", 1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0);
    reset    = 1'b0;
    bus.hit  = 1'b1;
    bus.goal = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      expect_all($sformatf("post_reset%0d", k), 1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
